mmio_test_monitor: RTL and testbench



---
 rtl/mmio_test_pkg.sv | 30 +++
 rtl/mmio_test_monitor_fifo.sv | 51 +++++
 rtl/mmio_test_monitor.sv | 143 ++++++++++++++
 tb/tb_mmio_test_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_test_pkg.sv
// Shared register map, state encoding and console entry layout for the test monitor.
package mmio_test_pkg;

  // Word offsets (DataAdr[5:2]) within the 64-byte window
  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_CYCLE  = 4'h1;
  localparam logic [3:0] OFF_LED    = 4'h2;
  localparam logic [3:0] OFF_EXIT   = 4'h3;
  localparam logic [3:0] OFF_CON0   = 4'h4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TMO  = 2'd3
  } state_t;

  localparam int unsigned ST_RUN       = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_PASS      = 2;
  localparam int unsigned ST_TIMEOUT   = 3;
  localparam int unsigned ST_OVERFLOW  = 4;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] data;
  } con_entry_t;

endpackage

// File: rtl/mmio_test_monitor_fifo.sv
// Synchronous FIFO; push while full is accepted only when a pop happens the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_test_monitor.sv
// Memory-mapped test/status peripheral: exit code, watchdog, LEDs and buffered console.
module mmio_test_monitor
  import mmio_test_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PASS_CODE  = 55,
  parameter int unsigned MAX_CYCLES = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic [31:0]         DataAdr,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic [NUM_LEDS-1:0] led,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic                con_valid,
  input  logic                con_ready,
  output logic [2:0]          con_ch,
  output logic [31:0]         con_data
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned CON_END = OFF_CON0 + NUM_CH;

  state_t        state, state_n;
  logic          done_n, pass_n, tmo_n;
  logic [31:0]   cycle;
  logic          overflow;
  logic          hit, wr, exit_wr, con_hit, con_push, con_pop;
  logic [3:0]    off;
  logic          full, empty;
  logic [CW-1:0] count;
  con_entry_t    entry, head;
  logic [31:0]   status;
  logic          unused_c;

  assign hit      = (DataAdr[31:6] == BASE_ADDR[31:6]);
  assign off      = DataAdr[5:2];
  assign wr       = MemWrite & hit;
  assign exit_wr  = wr & (off == OFF_EXIT);
  assign con_hit  = (off >= OFF_CON0) && (32'(off) < CON_END);
  assign con_push = wr & con_hit;
  assign con_pop  = con_ready & ~empty;
  assign unused_c = &{1'b0, DataAdr[1:0]};

  assign entry.ch   = 3'(off - OFF_CON0);
  assign entry.data = WriteData;

  sync_fifo #(
    .WIDTH ($bits(con_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (con_push),
    .pop   (con_pop),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign con_valid = ~empty;
  assign con_ch    = con_valid ? head.ch   : '0;
  assign con_data  = con_valid ? head.data : '0;

  // An EXIT write on the expiry cycle takes priority over the watchdog
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    pass_n  = 1'b0;
    tmo_n   = 1'b0;
    case (state)
      RUN: begin
        if (exit_wr)
          state_n = (WriteData == 32'(PASS_CODE)) ? PASS : FAIL;
        else if (cycle == 32'(MAX_CYCLES - 1))
          state_n = TMO;
      end
      default: ;
    endcase
    done_n = (state_n != RUN);
    pass_n = (state_n == PASS);
    tmo_n  = (state_n == TMO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      done    <= done_n;
      pass    <= pass_n;
      timeout <= tmo_n;
    end
  end

  // Cycle counter freezes on the edge that leaves RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle    <= '0;
      led      <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == RUN && state_n == RUN) cycle <= cycle + 32'd1;
      if (wr && off == OFF_LED) led <= WriteData[NUM_LEDS-1:0];
      if (con_push && full && !con_pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    status                        = '0;
    status[ST_RUN]                = (state == RUN);
    status[ST_DONE]               = done;
    status[ST_PASS]               = pass;
    status[ST_TIMEOUT]            = timeout;
    status[ST_OVERFLOW]           = overflow;
    status[ST_COUNT_LSB +: 8]     = 8'(count);
  end

  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: ReadData = status;
        OFF_CYCLE:  ReadData = cycle;
        OFF_LED:    ReadData = 32'(led);
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_test_monitor.sv
// Randomized self-checking bench for mmio_test_monitor against a queue-based reference model.
module tb_mmio_test_monitor;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam int unsigned MAXC   = 100;
  localparam int unsigned DEP    = 4;
  localparam int unsigned NCH    = 4;
  localparam int unsigned PCODE  = 55;
  localparam logic [31:0] A_STAT = BASE + 32'h00;
  localparam logic [31:0] A_CYC  = BASE + 32'h04;
  localparam logic [31:0] A_LED  = BASE + 32'h08;
  localparam logic [31:0] A_EXIT = BASE + 32'h0C;
  localparam logic [31:0] A_CON0 = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic        done, pass, timeout, con_valid;
  logic        con_ready = 1'b0;
  logic [2:0]  con_ch;
  logic [31:0] con_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_done, m_pass, m_tmo, m_ovf;
  int unsigned m_cycle;
  logic [7:0]  m_led;
  logic [34:0] q[$];

  mmio_test_monitor #(
    .BASE_ADDR (BASE),
    .NUM_CH    (NCH),
    .DEPTH     (DEP),
    .NUM_LEDS  (8),
    .PASS_CODE (PCODE),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .led       (led),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .con_ch    (con_ch),
    .con_data  (con_data)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [31:0] adr);
    logic [31:0] r;
    logic [3:0]  o;
    r = '0;
    o = adr[5:2];
    if ((adr >> 6) != (BASE >> 6)) return r;
    case (o)
      4'h0: r = {16'b0, 8'(q.size()), 3'b0, m_ovf, m_tmo, m_pass, m_done, !m_done};
      4'h1: r = m_cycle;
      4'h2: r = {24'b0, m_led};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [34:0] exp_head();
    return (q.size() != 0) ? q[0] : 35'b0;
  endfunction

  // Applies the rules of one clock edge to the model, using the inputs present at that edge
  task automatic model_step();
    bit         h, popn;
    logic [3:0] o;
    if (reset) begin
      m_done = 0; m_pass = 0; m_tmo = 0; m_ovf = 0;
      m_cycle = 0; m_led = '0; q.delete();
      return;
    end
    h    = ((DataAdr >> 6) == (BASE >> 6));
    o    = DataAdr[5:2];
    popn = (q.size() != 0) && con_ready;
    if (!m_done) begin
      if (MemWrite && h && o == 4'h3) begin
        m_done = 1; m_pass = (WriteData == PCODE);
      end else if (m_cycle == MAXC - 1) begin
        m_done = 1; m_tmo = 1;
      end else begin
        m_cycle++;
      end
    end
    if (MemWrite && h && o == 4'h2) m_led = WriteData[7:0];
    if (popn) void'(q.pop_front());
    if (MemWrite && h && o >= 4 && o < 4 + NCH) begin
      if (q.size() == DEP) m_ovf = 1;
      else q.push_back({3'(o - 4'd4), WriteData});
    end
  endtask

  task automatic cyc(input logic mw, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
    MemWrite = mw; DataAdr = adr; WriteData = wd; con_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic peek(input logic [31:0] adr);
    MemWrite = 1'b0; DataAdr = adr;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 32'h0, 32'h0, 0);
    cyc(0, 32'h0, 32'h0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({done, pass, timeout, con_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {done, pass, timeout, con_valid});
    end
    n_vec++;
    if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h want 00", led); end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'h1) begin n_err++; $display("FAIL reset_status: got %h want 00000001", ReadData); end
    peek(A_CYC);
    n_vec++;
    if (ReadData !== 32'h0) begin n_err++; $display("FAIL reset_cycle: got %h want 0", ReadData); end
  endtask

  task automatic test_pass();
    int n;
    do_reset();
    n = $urandom_range(1, 20);
    repeat (n) cyc(0, 32'h0, 32'h0, 0);
    cyc(1, A_EXIT, 32'd55, 0);
    n_vec++;
    if ({done, pass, timeout} !== 3'b110) begin
      n_err++; $display("FAIL pass_flags: got %b want 110", {done, pass, timeout});
    end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'h6) begin n_err++; $display("FAIL pass_status: got %h want 00000006", ReadData); end
    peek(A_CYC);
    n_vec++;
    if (ReadData !== 32'(n)) begin n_err++; $display("FAIL pass_cycle: got %0d want %0d", ReadData, n); end
    repeat (5) cyc(0, 32'h0, 32'h0, 0);
    peek(A_CYC);
    n_vec++;
    if (ReadData !== 32'(n)) begin n_err++; $display("FAIL pass_cycle_frozen: got %0d want %0d", ReadData, n); end
  endtask

  task automatic test_fail();
    logic [31:0] code;
    do_reset();
    code = $urandom;
    if (code == 32'd55) code = 32'd7;
    cyc(1, A_EXIT, code, 0);
    n_vec++;
    if ({done, pass, timeout} !== 3'b100) begin
      n_err++; $display("FAIL fail_flags: got %b want 100", {done, pass, timeout});
    end
    cyc(1, A_EXIT, 32'd55, 0);
    n_vec++;
    if ({done, pass, timeout} !== 3'b100) begin
      n_err++; $display("FAIL fail_sticky: got %b want 100", {done, pass, timeout});
    end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'h2) begin n_err++; $display("FAIL fail_status: got %h want 00000002", ReadData); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      cyc(0, 32'h0, 32'h0, 0);
      n_vec++;
      if ({done, timeout} !== {2{i == 100}}) begin
        n_err++; $display("FAIL tmo_cycle%0d: got %b want %b", i, {done, timeout}, {2{i == 100}});
      end
    end
    peek(A_CYC);
    n_vec++;
    if (ReadData !== 32'd99) begin n_err++; $display("FAIL tmo_cycle_val: got %0d want 99", ReadData); end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'hA) begin n_err++; $display("FAIL tmo_status: got %h want 0000000a", ReadData); end
    do_reset();
    repeat (99) cyc(0, 32'h0, 32'h0, 0);
    cyc(1, A_EXIT, 32'd55, 0);
    n_vec++;
    if ({done, pass, timeout} !== 3'b110) begin
      n_err++; $display("FAIL tmo_exit_wins: got %b want 110", {done, pass, timeout});
    end
  endtask

  task automatic test_console();
    logic [34:0] exp_e [3];
    exp_e[0] = {3'd0, 32'hA};
    exp_e[1] = {3'd0, 32'hB};
    exp_e[2] = {3'd1, 32'hC};
    do_reset();
    cyc(1, A_CON0, 32'hA, 0);
    cyc(1, A_CON0, 32'hB, 0);
    cyc(1, A_CON0 + 32'h4, 32'hC, 0);
    cyc(0, 32'h0, 32'h0, 0);
    peek(A_STAT);
    n_vec++;
    if (ReadData[15:8] !== 8'd3) begin n_err++; $display("FAIL con_count: got %0d want 3", ReadData[15:8]); end
    n_vec++;
    if ({con_valid, con_ch, con_data} !== {1'b1, exp_e[0]}) begin
      n_err++; $display("FAIL con_hold: got %h want %h", {con_valid, con_ch, con_data}, {1'b1, exp_e[0]});
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({con_valid, con_ch, con_data} !== {1'b1, exp_e[i]}) begin
        n_err++; $display("FAIL con_pop%0d: got %h want %h", i, {con_valid, con_ch, con_data}, {1'b1, exp_e[i]});
      end
      cyc(0, 32'h0, 32'h0, 1);
    end
    n_vec++;
    if ({con_valid, con_ch, con_data} !== 36'h0) begin
      n_err++; $display("FAIL con_empty: got %h want 0", {con_valid, con_ch, con_data});
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d [6];
    logic [34:0] exp_e [4];
    do_reset();
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    for (int i = 0; i < 5; i++) cyc(1, A_CON0 + 32'(4 * (i % 4)), d[i], 0);
    peek(A_STAT);
    n_vec++;
    if ({ReadData[15:8], ReadData[4]} !== {8'd4, 1'b1}) begin
      n_err++; $display("FAIL ovf_status: got %h want count 4 ovf 1", ReadData);
    end
    cyc(1, A_CON0 + 32'h8, d[5], 1);
    peek(A_STAT);
    n_vec++;
    if (ReadData[15:8] !== 8'd4) begin n_err++; $display("FAIL ovf_pushpop_count: got %0d want 4", ReadData[15:8]); end
    exp_e[0] = {3'd1, d[1]};
    exp_e[1] = {3'd2, d[2]};
    exp_e[2] = {3'd3, d[3]};
    exp_e[3] = {3'd2, d[5]};
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({con_ch, con_data} !== exp_e[i]) begin
        n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, {con_ch, con_data}, exp_e[i]);
      end
      cyc(0, 32'h0, 32'h0, 1);
    end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'h11) begin n_err++; $display("FAIL ovf_sticky: got %h want 00000011", ReadData); end
  endtask

  task automatic test_led();
    logic [31:0] v;
    cyc(1, A_LED, 32'hFFFF_FF5A, 0);
    n_vec++;
    if (led !== 8'h5A) begin n_err++; $display("FAIL led_out: got %h want 5a", led); end
    peek(A_LED + 32'h1);
    n_vec++;
    if (ReadData !== 32'h5A) begin n_err++; $display("FAIL led_read: got %h want 0000005a", ReadData); end
    peek(A_EXIT);
    n_vec++;
    if (ReadData !== 32'h0) begin n_err++; $display("FAIL exit_read: got %h want 0", ReadData); end
    peek(BASE + 32'h3C);
    n_vec++;
    if (ReadData !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", ReadData); end
    peek(32'h0300_0008);
    n_vec++;
    if (ReadData !== 32'h0) begin n_err++; $display("FAIL nohit_read: got %h want 0", ReadData); end
    cyc(1, A_EXIT, 32'd9, 0);
    v = $urandom;
    cyc(1, A_LED, v, 0);
    n_vec++;
    if (led !== v[7:0]) begin n_err++; $display("FAIL led_terminal: got %h want %h", led, v[7:0]); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, A_LED, 32'h33, 0);
    for (int i = 0; i < 3; i++) cyc(1, A_CON0 + 32'(4 * i), $urandom, 0);
    repeat (4) cyc(0, 32'h0, 32'h0, 0);
    reset = 1'b1;
    cyc(0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    n_vec++;
    if ({led, con_valid, done} !== 10'h0) begin
      n_err++; $display("FAIL midrst_outs: got %h want 0", {led, con_valid, done});
    end
    peek(A_STAT);
    n_vec++;
    if (ReadData !== 32'h1) begin n_err++; $display("FAIL midrst_status: got %h want 00000001", ReadData); end
    peek(A_CYC);
    n_vec++;
    if (ReadData !== 32'h0) begin n_err++; $display("FAIL midrst_cycle: got %h want 0", ReadData); end
  endtask

  task automatic test_random();
    int          r;
    logic        mw;
    logic [31:0] adr, wd;
    logic [83:0] obs, expv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       adr = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      else if (r == 8) adr = BASE + 32'(4 * $urandom_range(8, 15));
      else             adr = $urandom;
      mw = 1'($urandom_range(0, 1));
      wd = ($urandom_range(0, 3) == 0) ? 32'd55 : $urandom;
      if (r == 3 && $urandom_range(0, 9) != 0) mw = 1'b0;
      reset = ($urandom_range(0, 149) == 0);
      cyc(mw, adr, wd, 1'($urandom_range(0, 1)));
      obs  = {done, pass, timeout, con_valid, con_ch, con_data, led, ReadData};
      expv = {m_done, m_pass, m_tmo, 1'(q.size() != 0), exp_head(), m_led, exp_rd(adr)};
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL random%0d: got %h want %h", i, obs, expv);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_console();
    test_overflow();
    test_led();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
